// File: rtl/sdp_read_streamer.sv
// rtl/sdp_read_streamer.sv - strided burst reader for an SDP block-RAM, latency-absorbing, valid/ready stream out
// Optional abort input and in-flight drop logic: define SDP_STREAM_ABORT_EN
module sdp_read_streamer #(
    parameter int READ_WIDTH      = 8,
    parameter int READ_ADDR_WIDTH = 8,
    parameter int READ_LATENCY_B  = 1,
    parameter int COUNT_WIDTH     = 16,
    parameter int OBUF_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [READ_ADDR_WIDTH-1:0] req_base_addr,
    input  logic [COUNT_WIDTH-1:0]     req_count,
    input  logic [READ_ADDR_WIDTH-1:0] req_stride,
    output logic [READ_ADDR_WIDTH-1:0] mem_addrb,
    output logic                       mem_enb,
    output logic                       mem_regceb,
    input  logic [READ_WIDTH-1:0]      mem_doutb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [READ_WIDTH-1:0]      out_data,
    output logic                       out_last,
`ifdef SDP_STREAM_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       done
);
    localparam int PTR_W = $clog2(OBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]       PTR_ONE    = PTR_W'(1);
    localparam logic [COUNT_WIDTH-1:0] REM_ONE    = COUNT_WIDTH'(1);
    localparam logic [CNT_W:0]         CREDIT_LIM = (CNT_W+1)'(OBUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ABORT} state_t;
    state_t state;

    logic [READ_ADDR_WIDTH-1:0] addr;
    logic [READ_ADDR_WIDTH-1:0] stride;
    logic [COUNT_WIDTH-1:0]     remaining;
    logic                       mem_last;
    logic [READ_LATENCY_B-1:0]  tag_valid;
    logic [READ_LATENCY_B-1:0]  tag_last;
    logic [CNT_W-1:0]           inflight;
    logic [CNT_W-1:0]           inflight_next;
    logic [CNT_W-1:0]           obuf_count;
    logic [CNT_W:0]             credit_used;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [READ_WIDTH-1:0]      obuf_data [OBUF_DEPTH];
    logic [OBUF_DEPTH-1:0]      obuf_last;
    logic                       tail_valid;
    logic                       tail_last;
    logic                       push;
    logic                       pop;
    logic                       can_issue;
    logic                       drain_done;

    assign mem_regceb = 1'b1;
    assign tail_valid = tag_valid[READ_LATENCY_B-1];
    assign tail_last  = tag_last[READ_LATENCY_B-1];
    assign out_valid  = (obuf_count != '0);
    assign out_data   = obuf_data[rd_ptr];
    assign out_last   = obuf_last[rd_ptr];
    assign pop        = out_valid && out_ready;
    assign credit_used = {1'b0, inflight} + {1'b0, obuf_count};

`ifdef SDP_STREAM_ABORT_EN
    logic abort_hit;
    logic dropping;
    assign abort_hit = abort && (state == S_ISSUE || state == S_DRAIN);
    // Data returning for an aborted burst is never written into the buffer
    assign push      = tail_valid && !dropping && !abort_hit;
    assign can_issue = (state == S_ISSUE) && (remaining != '0) && (credit_used < CREDIT_LIM) && !abort_hit;
`else
    assign push      = tail_valid;
    assign can_issue = (state == S_ISSUE) && (remaining != '0) && (credit_used < CREDIT_LIM);
`endif

    // A read holds one credit from the issue decision until its data lands in the buffer
    always_comb begin
        inflight_next = inflight;
        if (can_issue && !tail_valid) begin
            inflight_next = inflight + CNT_ONE;
        end else if (!can_issue && tail_valid) begin
            inflight_next = inflight - CNT_ONE;
        end
    end

    // Finished when nothing is in flight and the final beat leaves this cycle (or already left)
    assign drain_done = (inflight == '0) && !tail_valid &&
                        ((obuf_count == '0) || ((obuf_count == CNT_ONE) && pop));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
            mem_last  <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            stride    <= '0;
            remaining <= '0;
            inflight  <= '0;
            tag_valid <= '0;
            tag_last  <= '0;
`ifdef SDP_STREAM_ABORT_EN
            dropping  <= 1'b0;
`endif
        end else begin
            done         <= 1'b0;
            mem_enb      <= can_issue;
            mem_last     <= can_issue && (remaining == REM_ONE);
            inflight     <= inflight_next;
            tag_valid[0] <= mem_enb;
            tag_last[0]  <= mem_last;
            for (int i = 1; i < READ_LATENCY_B; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            if (can_issue) begin
                mem_addrb <= addr;
                addr      <= addr + stride;
                remaining <= remaining - REM_ONE;
            end
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        addr      <= req_base_addr;
                        stride    <= req_stride;
                        remaining <= req_count;
                        if (req_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            req_ready <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (can_issue && remaining == REM_ONE) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        done      <= 1'b1;
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
`ifdef SDP_STREAM_ABORT_EN
                S_ABORT: begin
                    if (inflight_next == '0) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        dropping  <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
`ifdef SDP_STREAM_ABORT_EN
            if (abort_hit) begin
                done      <= 1'b0;
                state     <= (inflight_next == '0) ? S_IDLE : S_ABORT;
                req_ready <= (inflight_next == '0);
                dropping  <= (inflight_next != '0);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            obuf_count <= '0;
            obuf_last  <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                obuf_data[i] <= '0;
            end
`ifdef SDP_STREAM_ABORT_EN
        end else if (abort_hit) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            obuf_count <= '0;
`endif
        end else begin
            if (push) begin
                obuf_data[wr_ptr] <= mem_doutb;
                obuf_last[wr_ptr] <= tail_last;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                obuf_count <= obuf_count + CNT_ONE;
            end else if (!push && pop) begin
                obuf_count <= obuf_count - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_sdp_read_streamer.sv
// tb/tb_sdp_read_streamer.sv - directed self-checking bench for sdp_read_streamer (latency 1 and latency 3 instances)
module tb_sdp_read_streamer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        a_req_valid, a_req_ready, a_enb, a_regceb, a_out_valid, a_out_ready, a_out_last, a_done;
    logic [7:0]  a_base, a_stride, a_addrb, a_dout, a_out_data;
    logic [15:0] a_count;
    logic        b_req_valid, b_req_ready, b_enb, b_regceb, b_out_valid, b_out_ready, b_out_last, b_done;
    logic [7:0]  b_base, b_stride, b_addrb, b_dout, b_out_data;
    logic [15:0] b_count;
`ifdef SDP_STREAM_ABORT_EN
    logic a_abort = 1'b0;
    logic b_abort = 1'b0;
`endif

    sdp_read_streamer dut_a (
        .clk(clk), .resetn(resetn),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_base_addr(a_base), .req_count(a_count), .req_stride(a_stride),
        .mem_addrb(a_addrb), .mem_enb(a_enb), .mem_regceb(a_regceb), .mem_doutb(a_dout),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
`ifdef SDP_STREAM_ABORT_EN
        .abort(a_abort),
`endif
        .done(a_done)
    );

    sdp_read_streamer #(.READ_LATENCY_B(3), .OBUF_DEPTH(8)) dut_b (
        .clk(clk), .resetn(resetn),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_base_addr(b_base), .req_count(b_count), .req_stride(b_stride),
        .mem_addrb(b_addrb), .mem_enb(b_enb), .mem_regceb(b_regceb), .mem_doutb(b_dout),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
`ifdef SDP_STREAM_ABORT_EN
        .abort(b_abort),
`endif
        .done(b_done)
    );

    // RAM models with mem[a] = a
    logic [7:0] a_pipe = '0;
    logic [7:0] b_p0 = '0, b_p1 = '0, b_p2 = '0;
    always @(posedge clk) begin
        if (a_enb) a_pipe <= a_addrb;
        if (b_enb) b_p0 <= b_addrb;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign a_dout = a_pipe;
    assign b_dout = b_p2;

    logic [8:0] a_beats[$];
    logic [8:0] b_beats[$];
    logic [7:0] a_reads[$];
    int a_read_cyc[$];
    int b_beat_cyc[$];
    int b_nreads, a_done_cnt, b_done_cnt, a_done_cyc, a_last_hs_cyc, a_outv_cnt;

    always @(negedge clk) begin
        cyc++;
        if (resetn) begin
            if (a_enb) begin a_reads.push_back(a_addrb); a_read_cyc.push_back(cyc); end
            if (a_out_valid && a_out_ready) begin a_beats.push_back({a_out_last, a_out_data}); a_last_hs_cyc = cyc; end
            if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
            if (a_out_valid) a_outv_cnt++;
            if (b_enb) b_nreads++;
            if (b_out_valid && b_out_ready) begin b_beats.push_back({b_out_last, b_out_data}); b_beat_cyc.push_back(cyc); end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        a_beats.delete(); b_beats.delete(); a_reads.delete(); a_read_cyc.delete(); b_beat_cyc.delete();
        b_nreads = 0; a_done_cnt = 0; b_done_cnt = 0; a_done_cyc = -100; a_last_hs_cyc = -200; a_outv_cnt = 0;
    endtask

    task automatic send_a(input logic [7:0] base, input logic [15:0] cnt, input logic [7:0] strd);
        int k = 0;
        while (a_req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        chk("a_req_ready_wait", a_req_ready, 1);
        a_base = base; a_count = cnt; a_stride = strd; a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] base, input logic [15:0] cnt, input logic [7:0] strd);
        int k = 0;
        while (b_req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        chk("b_req_ready_wait", b_req_ready, 1);
        b_base = base; b_count = cnt; b_stride = strd; b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] wrap_addr [3];
        int n_beats, n_reads, k;
        wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'h01; wrap_addr[2] = 8'h04;
        a_req_valid = 0; a_base = 0; a_count = 0; a_stride = 0; a_out_ready = 1;
        b_req_valid = 0; b_base = 0; b_count = 0; b_stride = 0; b_out_ready = 1;
        clear_mon();

        // reset values
        #22;
        chk("rst_req_ready", a_req_ready, 0);
        chk("rst_enb", a_enb, 0);
        chk("rst_addrb", a_addrb, 0);
        chk("rst_regceb", a_regceb, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_done", a_done, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("post_rst_req_ready0", a_req_ready, 0);
        wait_cycles(1);
        chk("post_rst_req_ready1", a_req_ready, 1);
        chk("post_rst_b_req_ready1", b_req_ready, 1);
        chk("post_rst_enb", a_enb, 0);

        // basic burst
        clear_mon();
        send_a(8'h10, 16'd4, 8'h01);
        wait_cycles(20);
        chk("basic_nreads", a_reads.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_read%0d", i), a_reads[i], 32'h10 + i);
        chk("basic_read_span", a_read_cyc[3] - a_read_cyc[0], 3);
        chk("basic_nbeats", a_beats.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_beat%0d", i), a_beats[i], (i == 3 ? 256 : 0) + 32'h10 + i);
        chk("basic_done_cnt", a_done_cnt, 1);
        chk("basic_done_timing", a_done_cyc, a_last_hs_cyc + 1);

        // strided wrap-around
        clear_mon();
        send_a(8'hFE, 16'd3, 8'h03);
        wait_cycles(20);
        chk("wrap_nreads", a_reads.size(), 3);
        chk("wrap_nbeats", a_beats.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_read%0d", i), a_reads[i], wrap_addr[i]);
            chk($sformatf("wrap_beat%0d", i), a_beats[i], (i == 2 ? 256 : 0) + wrap_addr[i]);
        end
        chk("wrap_done_cnt", a_done_cnt, 1);

        // back-pressure
        clear_mon();
        a_out_ready = 1'b0;
        send_a(8'h20, 16'd8, 8'h01);
        wait_cycles(10);
        chk("bp_nreads_stalled", a_reads.size(), 4);
        chk("bp_enb_stalled", a_enb, 0);
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_out_data_held", a_out_data, 8'h20);
        chk("bp_nbeats_stalled", a_beats.size(), 0);
        a_out_ready = 1'b1;
        wait_cycles(25);
        chk("bp_nreads", a_reads.size(), 8);
        chk("bp_nbeats", a_beats.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_beat%0d", i), a_beats[i], (i == 7 ? 256 : 0) + 32'h20 + i);
        chk("bp_done_cnt", a_done_cnt, 1);

        // zero count
        clear_mon();
        send_a(8'h30, 16'd0, 8'h01);
        wait_cycles(6);
        chk("zero_done_cnt", a_done_cnt, 1);
        chk("zero_nreads", a_reads.size(), 0);
        chk("zero_outv", a_outv_cnt, 0);
        chk("zero_req_ready", a_req_ready, 1);

        // latency 3, depth 8
        clear_mon();
        send_b(8'h40, 16'd16, 8'h01);
        wait_cycles(40);
        chk("lat3_nreads", b_nreads, 16);
        chk("lat3_nbeats", b_beats.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("lat3_beat%0d", i), b_beats[i], (i == 15 ? 256 : 0) + 32'h40 + i);
        chk("lat3_rate", b_beat_cyc[15] - b_beat_cyc[0], 15);
        chk("lat3_done_cnt", b_done_cnt, 1);

`ifdef SDP_STREAM_ABORT_EN
        // abort mid-burst
        clear_mon();
        send_a(8'h60, 16'd10, 8'h01);
        k = 0;
        while (a_beats.size() < 2 && k < 50) begin @(posedge clk); #1; k++; end
        chk("abort_two_beats", a_beats.size() >= 2, 1);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        n_beats = a_beats.size();
        n_reads = a_reads.size();
        chk("abort_flush", a_out_valid, 0);
        k = 0;
        while (a_req_ready !== 1'b1 && k < 5) begin @(posedge clk); #1; k++; end
        chk("abort_ready_latency", k <= 1, 1);
        wait_cycles(10);
        chk("abort_no_beats", a_beats.size(), n_beats);
        chk("abort_no_reads", a_reads.size(), n_reads);
        chk("abort_no_done", a_done_cnt, 0);
`endif

        // reset mid-burst
        clear_mon();
        send_a(8'h50, 16'd8, 8'h01);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("midrst_enb", a_enb, 0);
        chk("midrst_addrb", a_addrb, 0);
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_data", a_out_data, 0);
        chk("midrst_req_ready", a_req_ready, 0);
        chk("midrst_done", a_done, 0);
        clear_mon();
        @(posedge clk); #1;
        resetn = 1'b1;
        wait_cycles(4);
        chk("midrst_req_ready_back", a_req_ready, 1);
        chk("midrst_no_reads", a_reads.size(), 0);
        chk("midrst_no_beats", a_beats.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
